// File: rtl/enemy_wave_ctl.sv
// enemy_wave_ctl: sequences enemy waves. Spawns enemies one at a time on a
// move-tick schedule, retires them on hit, pauses once the screen is clear,
// then advances to the next wave or declares the game won.
module enemy_wave_ctl #(
  parameter int N_EN        = 3,
  parameter int N_WAVES     = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int SPAWN_GAP   = 16,
  parameter int CLEAR_DELAY = 64
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            start,
  input  logic [N_EN-1:0] hit,
  output logic [N_EN-1:0] en_on,
  output logic            move_tick,
  output logic            path_rst,
  output logic [3:0]      wave,
  output logic            wave_done,
  output logic            game_won
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SPAWN,
    S_ACTIVE,
    S_CLEAR,
    S_WON
  } state_t;

  localparam logic [20:0] TICK_LAST = 21'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(SPAWN_GAP - 1);
  localparam logic [7:0]  CLR_LAST  = 8'(CLEAR_DELAY - 1);
  localparam logic [3:0]  EN_CNT    = 4'(N_EN);
  localparam logic [3:0]  WAVE_LAST = 4'(N_WAVES - 1);

  state_t          state_q, state_d;
  logic [20:0]     tick_cnt_q, tick_cnt_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [3:0]      spawn_idx_q, spawn_idx_d;
  logic [N_EN-1:0] en_on_q, en_on_d;
  logic            move_tick_q, move_tick_d;
  logic            path_rst_q, path_rst_d;
  logic [3:0]      wave_q, wave_d;
  logic            wave_done_q, wave_done_d;
  logic            game_won_q, game_won_d;

  logic run_q, run_d;
  logic tick_ev, spawn_ev, clear_ev;

  // The tick divider only runs while enemies can be on screen or the clear
  // pause is timing out; tick_ev marks the edge on which it wraps.
  assign run_q    = (state_q == S_SPAWN) || (state_q == S_ACTIVE) || (state_q == S_CLEAR);
  assign run_d    = (state_d == S_SPAWN) || (state_d == S_ACTIVE) || (state_d == S_CLEAR);
  assign tick_ev  = run_q && (tick_cnt_q == TICK_LAST);
  assign spawn_ev = (state_q == S_SPAWN) && (spawn_idx_q < EN_CNT) &&
                    tick_ev && (gap_cnt_q == GAP_LAST);
  assign clear_ev = (state_q == S_CLEAR) && tick_ev && (gap_cnt_q == CLR_LAST);

  // State and registered outputs; everything returns to idle on rst.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      spawn_idx_q <= '0;
      en_on_q     <= '0;
      move_tick_q <= 1'b0;
      path_rst_q  <= 1'b0;
      wave_q      <= '0;
      wave_done_q <= 1'b0;
      game_won_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      spawn_idx_q <= spawn_idx_d;
      en_on_q     <= en_on_d;
      move_tick_q <= move_tick_d;
      path_rst_q  <= path_rst_d;
      wave_q      <= wave_d;
      wave_done_q <= wave_done_d;
      game_won_q  <= game_won_d;
    end
  end

  // Next-state selection for the wave sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_SPAWN;
      S_SPAWN:  if (spawn_idx_q == EN_CNT) state_d = S_ACTIVE;
      S_ACTIVE: if (en_on_q == '0) state_d = S_CLEAR;
      S_CLEAR:  if (clear_ev) state_d = (wave_q == WAVE_LAST) ? S_WON : S_LOAD;
      S_WON:    if (start) state_d = S_LOAD;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, enemy enables and output pulses for the next cycle.
  always_comb begin
    tick_cnt_d  = (run_q && run_d) ? (tick_ev ? '0 : tick_cnt_q + 21'd1) : '0;
    move_tick_d = tick_ev && run_d;
    path_rst_d  = (state_d == S_LOAD);
    game_won_d  = (state_d == S_WON);
    wave_done_d = clear_ev;
    gap_cnt_d   = gap_cnt_q;
    spawn_idx_d = spawn_idx_q;
    en_on_d     = en_on_q;
    wave_d      = wave_q;

    if (clear_ev && (wave_q != WAVE_LAST)) wave_d = wave_q + 4'd1;
    if ((state_q == S_WON) && start)       wave_d = '0;

    case (state_q)
      S_LOAD: begin
        // Entry edge into SPAWN: first enemy appears immediately.
        gap_cnt_d   = '0;
        spawn_idx_d = 4'd1;
        en_on_d     = '0;
        en_on_d[0]  = 1'b1;
      end
      S_SPAWN: begin
        en_on_d = en_on_q & ~hit;
        if (spawn_ev) begin
          // Spawn is applied after the hit mask so it wins on a same-edge hit.
          for (int i = 0; i < N_EN; i++) begin
            if (spawn_idx_q == 4'(i)) en_on_d[i] = 1'b1;
          end
          spawn_idx_d = spawn_idx_q + 4'd1;
          gap_cnt_d   = '0;
        end else if (tick_ev) begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      S_ACTIVE: begin
        en_on_d = en_on_q & ~hit;
        if (en_on_q == '0) gap_cnt_d = '0;
      end
      S_CLEAR: begin
        if (tick_ev) gap_cnt_d = clear_ev ? '0 : gap_cnt_q + 8'd1;
      end
      default: begin
      end
    endcase
  end

  assign en_on     = en_on_q;
  assign move_tick = move_tick_q;
  assign path_rst  = path_rst_q;
  assign wave      = wave_q;
  assign wave_done = wave_done_q;
  assign game_won  = game_won_q;

endmodule
